// File: rtl/blink_pkg.sv
// Shared blink engine types: pattern codes, phase table, channel states.
// Table entries are in 0.1 s units; count 0 means the train never ends.
package blink_pkg;

  localparam int UNIT_W = 4;

  typedef enum logic [1:0] {
    PAT_ERROR     = 2'd0,
    PAT_SUCCESS   = 2'd1,
    PAT_WARN      = 2'd2,
    PAT_HEARTBEAT = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [UNIT_W-1:0] on;
    logic [UNIT_W-1:0] off;
    logic [UNIT_W-1:0] count;
  } pat_cfg_t;

  function automatic pat_cfg_t pat_cfg(pat_e p);
    pat_cfg = '{on: 4'd1, off: 4'd9, count: 4'd0};
    unique case (p)
      PAT_ERROR:     pat_cfg = '{on: 4'd5, off: 4'd10, count: 4'd3};
      PAT_SUCCESS:   pat_cfg = '{on: 4'd2, off: 4'd2,  count: 4'd5};
      PAT_WARN:      pat_cfg = '{on: 4'd1, off: 4'd1,  count: 4'd10};
      PAT_HEARTBEAT: pat_cfg = '{on: 4'd1, off: 4'd9,  count: 4'd0};
      default:       pat_cfg = '{on: 4'd1, off: 4'd9,  count: 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: start edge detect, IDLE/ON/OFF/DONE FSM, phase counters.
// Ports: hwclk, rst_n, start, pattern, abort in; lit, busy, done out.
module blink_channel
  import blink_pkg::*;
#(
  parameter int TICK_CYC  = 1200000,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] pattern,
  input  logic       abort,
  output logic       lit,
  output logic       busy,
  output logic       done
);

  localparam int CYC_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYC - 1);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [UNIT_W-1:0] blink_q, blink_d;
  pat_e              pat_q, pat_d;
  logic              start_q;

  pat_cfg_t cfg;
  logic     tick_end;
  logic     running;
  logic     go;

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      blink_q <= '0;
      pat_q   <= PAT_ERROR;
      // held-high start through reset must not look like an edge
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      blink_q <= blink_d;
      pat_q   <= pat_d;
      start_q <= start;
    end
  end

  always_comb begin
    cfg      = pat_cfg(pat_q);
    tick_end = (cyc_q == CYC_LAST);
    running  = (state_q == ST_ON) || (state_q == ST_OFF);
    go       = start && !start_q && (!running || RETRIGGER);
    state_d  = state_q;
    cyc_d    = cyc_q;
    unit_d   = unit_q;
    blink_d  = blink_q;
    pat_d    = pat_q;
    if (abort) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
      unit_d  = '0;
      blink_d = '0;
    end else if (go) begin
      state_d = ST_ON;
      cyc_d   = '0;
      unit_d  = '0;
      blink_d = '0;
      pat_d   = pat_e'(pattern);
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ON: begin
          cyc_d = cyc_q + 1'b1;
          if (tick_end) begin
            cyc_d  = '0;
            unit_d = unit_q + 1'b1;
            if (unit_q == cfg.on - 4'd1) begin
              unit_d  = '0;
              state_d = ST_OFF;
              // saturate so an endless train never aliases a count
              if (blink_q != '1)
                blink_d = blink_q + 1'b1;
            end
          end
        end
        ST_OFF: begin
          cyc_d = cyc_q + 1'b1;
          if (tick_end) begin
            cyc_d  = '0;
            unit_d = unit_q + 1'b1;
            if (unit_q == cfg.off - 4'd1) begin
              unit_d = '0;
              if (cfg.count != '0 && blink_q == cfg.count) begin
                state_d = ST_DONE;
                blink_d = '0;
              end else begin
                state_d = ST_ON;
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign lit  = (state_q == ST_ON);
  assign busy = running;
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/blink_sequencer.sv
// Multi-channel LED blink engine: NUM_CH independent table-driven channels.
// Ports: hwclk, rst_n, start_i, pattern_i, abort_i in; led_o, busy_o, done_o out.
module blink_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int CLK_HZ      = 12000000,
  parameter bit LED_ACT_LOW = 1'b0,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   start_i,
  input  logic [2*NUM_CH-1:0] pattern_i,
  input  logic [NUM_CH-1:0]   abort_i,
  output logic [NUM_CH-1:0]   led_o,
  output logic [NUM_CH-1:0]   busy_o,
  output logic [NUM_CH-1:0]   done_o
);

  localparam int TICK_CYC = (CLK_HZ / 10 > 0) ? CLK_HZ / 10 : 1;

  logic [NUM_CH-1:0] lit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    blink_channel #(
      .TICK_CYC  (TICK_CYC),
      .RETRIGGER (RETRIGGER)
    ) u_ch (
      .hwclk   (hwclk),
      .rst_n   (rst_n),
      .start   (start_i[c]),
      .pattern (pattern_i[2*c +: 2]),
      .abort   (abort_i[c]),
      .lit     (lit[c]),
      .busy    (busy_o[c]),
      .done    (done_o[c])
    );
  end

  assign led_o = LED_ACT_LOW ? ~lit : lit;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench: two DUTs (plain / retrigger+active-low) vs timeline model.
// Model derives outputs from elapsed cycles since each run's start edge.
module tb_blink_sequencer;

  localparam int T = 10;

  logic       hwclk;
  logic       rst_n;
  logic [3:0] start_i;
  logic [7:0] pattern_i;
  logic [3:0] abort_i;
  logic [3:0] led0, busy0, done0;
  logic [3:0] led1, busy1, done1;

  blink_sequencer #(
    .NUM_CH(4), .CLK_HZ(100), .LED_ACT_LOW(1'b0), .RETRIGGER(1'b0)
  ) u_dut0 (
    .hwclk(hwclk), .rst_n(rst_n), .start_i(start_i),
    .pattern_i(pattern_i), .abort_i(abort_i),
    .led_o(led0), .busy_o(busy0), .done_o(done0)
  );

  blink_sequencer #(
    .NUM_CH(4), .CLK_HZ(100), .LED_ACT_LOW(1'b1), .RETRIGGER(1'b1)
  ) u_dut1 (
    .hwclk(hwclk), .rst_n(rst_n), .start_i(start_i),
    .pattern_i(pattern_i), .abort_i(abort_i),
    .led_o(led1), .busy_o(busy1), .done_o(done1)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  int ON_U[4]  = '{5, 2, 1, 1};
  int OFF_U[4] = '{10, 2, 1, 9};
  int CNT[4]   = '{3, 5, 10, 0};
  bit RETRIG[2] = '{1'b0, 1'b1};
  bit ACTLOW[2] = '{1'b0, 1'b1};

  bit m_run[2][4];
  int m_t0[2][4];
  int m_pat[2][4];
  bit m_prev[2][4];

  logic [23:0] expq[$];
  bit mon_en = 1'b0;
  int n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_prt = 0;

  function automatic bit model_busy(int i, int c, int m);
    int p, per, e;
    if (!m_run[i][c]) return 1'b0;
    p = m_pat[i][c];
    per = (ON_U[p] + OFF_U[p]) * T;
    e = m - m_t0[i][c];
    if (CNT[p] != 0 && e >= CNT[p] * per) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [11:0] model_out(int i, int m);
    logic [3:0] led, bsy, dn;
    int p, per, e;
    led = '0; bsy = '0; dn = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_run[i][c]) begin
        p = m_pat[i][c];
        per = (ON_U[p] + OFF_U[p]) * T;
        e = m - m_t0[i][c];
        if (CNT[p] != 0 && e >= CNT[p] * per) begin
          dn[c] = (e == CNT[p] * per);
        end else begin
          bsy[c] = 1'b1;
          led[c] = (e % per) < ON_U[p] * T;
        end
      end
    end
    if (ACTLOW[i]) led = ~led;
    return {led, bsy, dn};
  endfunction

  task automatic drive(bit r, logic [3:0] s, logic [7:0] p, logic [3:0] a);
    bit ed;
    rst_n = r; start_i = s; pattern_i = p; abort_i = a;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!r) begin
          m_run[i][c] = 1'b0;
          m_prev[i][c] = 1'b1;
        end else begin
          ed = s[c] && !m_prev[i][c];
          m_prev[i][c] = s[c];
          if (a[c]) begin
            m_run[i][c] = 1'b0;
          end else if (ed) begin
            if (!model_busy(i, c, n - 1) || RETRIG[i]) begin
              m_run[i][c] = 1'b1;
              m_t0[i][c] = n;
              m_pat[i][c] = int'(p[2*c +: 2]);
            end
          end
        end
      end
    end
    expq.push_back({model_out(0, n), model_out(1, n)});
    mon_en = 1'b1;
    @(negedge hwclk);
    n++;
  endtask

  task automatic idle(int k);
    for (int j = 0; j < k; j++) drive(1'b1, 4'b0, 8'($urandom), 4'b0);
  endtask

  initial begin : monitor
    logic [23:0] e;
    logic [11:0] g;
    forever begin
      @(posedge hwclk);
      #1;
      if (mon_en) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL queue_empty at n=%0d", n);
        end else begin
          e = expq.pop_front();
          for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? {led0, busy0, done0} : {led1, busy1, done1};
            n_cmp++;
            if (g !== ((i == 0) ? e[23:12] : e[11:0])) begin
              n_bad++;
              if (n_prt < 25) begin
                n_prt++;
                $display("FAIL dut%0d_outputs cyc=%0d got led/busy/done=%h required=%h",
                         i, n, g, (i == 0) ? e[23:12] : e[11:0]);
              end
            end
          end
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] s;
    logic [3:0] a;
    bit r;
    for (int j = 0; j < 3; j++) drive(1'b0, 4'b0001, 8'($urandom), 4'b0);
    for (int j = 0; j < 3; j++) drive(1'b1, 4'b0001, 8'($urandom), 4'b0);
    idle(2);
    drive(1'b1, 4'b0001, 8'h00, 4'b0);
    idle(200);
    drive(1'b1, 4'b0001, 8'h01, 4'b0);
    idle(480);
    drive(1'b1, 4'b0110, 8'h24, 4'b0);
    idle(220);
    drive(1'b1, 4'b1000, 8'hC0, 4'b0);
    idle(600);
    drive(1'b1, 4'b0000, 8'($urandom), 4'b1000);
    idle(5);
    drive(1'b1, 4'b0001, 8'h00, 4'b0001);
    idle(5);
    drive(1'b1, 4'b0010, 8'h00, 4'b0);
    idle(100);
    drive(1'b0, 4'b0000, 8'($urandom), 4'b0);
    idle(5);
    s = '0;
    for (int k = 0; k < 15000; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (s[c]) begin
          if ($urandom_range(2) == 0) s[c] = 1'b0;
        end else if ($urandom_range(149) == 0) begin
          s[c] = 1'b1;
        end
        a[c] = ($urandom_range(1499) == 0);
      end
      r = ($urandom_range(5999) != 0);
      drive(r, s, 8'($urandom), a);
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
